// File: rtl/seg_decoder.sv
// -----------------------------------------------------------------------------
// seg_decoder
//
// Receive side of a 7-segment display link. The module samples an active-low
// segment bus, waits until a pattern has been stable for STABLE_CYCLES
// samples, and recovers the digit that produced it. Each new digit is offered
// once on a valid/ready pair. Blank and illegal patterns are flagged, and
// illegal ones are counted.
//
// Optional feature: when the macro SEG_DEC_HEX_EN is defined, digit_out is
// 4 bits wide and the hex patterns 8..F decode as legal digits. When it is
// undefined, digit_out is 3 bits wide and those patterns are illegal.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  segment bus, bit0=a .. bit6=g, active-low
//   seg_en       source enable; low means seg_in is not meaningful
//   digit_out    decoded digit (3 bits, or 4 with SEG_DEC_HEX_EN)
//   digit_valid  digit_out holds a digit not yet accepted
//   digit_ready  consumer accepts digit_out
//   blank        last accepted pattern was all segments off
//   err_pulse    one-cycle pulse when an illegal pattern is accepted
//   err_count    saturating count of illegal patterns
//   overrun      sticky: a pending digit was overwritten
//   clr_err      synchronous clear of err_count and overrun
//
// Handshake: digit_valid rises when a legal digit is decoded and stays high,
// with digit_out held constant, until a cycle where digit_valid and
// digit_ready are both high; it falls on the following edge unless a new
// digit loads on that same edge.
// -----------------------------------------------------------------------------
module seg_decoder #(
    parameter int STABLE_CYCLES = 3,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_in,
    input  logic                 seg_en,
`ifdef SEG_DEC_HEX_EN
    output logic [3:0]           digit_out,
`else
    output logic [2:0]           digit_out,
`endif
    output logic                 digit_valid,
    input  logic                 digit_ready,
    output logic                 blank,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overrun,
    input  logic                 clr_err
);

`ifdef SEG_DEC_HEX_EN
    localparam int DIGIT_W = 4;
`else
    localparam int DIGIT_W = 3;
`endif

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [0:0] ST_WAIT_STABLE = 1'b0;
    localparam logic [0:0] ST_LOCKED      = 1'b1;

    logic [6:0] seg_q;
    logic [3:0] stable_cnt;
    logic [0:0] state;
    logic [6:0] last_pat;
    logic       last_none;   // "no pattern accepted yet": the next stable one always emits

    logic               fire;
    logic [DIGIT_W:0]   dec;       // {legal, digit}
    logic               dec_legal;
    logic [DIGIT_W-1:0] dec_digit;
    logic               accept;
    logic [ERR_CNT_W-1:0] err_one;

    function automatic logic [DIGIT_W:0] legal_digit(input int unsigned d);
        return {1'b1, DIGIT_W'(d)};
    endfunction

    function automatic logic [DIGIT_W:0] decode(input logic [6:0] p);
        logic [DIGIT_W:0] r;
        r = '0;
        case (p)
            7'b1000000: r = legal_digit(0);
            7'b1111001: r = legal_digit(1);
            7'b0100100: r = legal_digit(2);
            7'b0110000: r = legal_digit(3);
            7'b0011001: r = legal_digit(4);
            7'b0010010: r = legal_digit(5);
            7'b0000010: r = legal_digit(6);
            7'b1111000: r = legal_digit(7);
`ifdef SEG_DEC_HEX_EN
            7'b0000000: r = legal_digit(8);
            7'b0010000: r = legal_digit(9);
            7'b0001000: r = legal_digit(10);
            7'b0000011: r = legal_digit(11);
            7'b1000110: r = legal_digit(12);
            7'b0100001: r = legal_digit(13);
            7'b0000110: r = legal_digit(14);
            7'b0001110: r = legal_digit(15);
`endif
            default:    r = '0;
        endcase
        return r;
    endfunction

    assign err_one   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    assign dec       = decode(seg_q);
    assign dec_legal = dec[DIGIT_W];
    assign dec_digit = dec[DIGIT_W-1:0];
    assign accept    = digit_valid && digit_ready;

    // A decode event happens once seg_q has been seen stable long enough and
    // differs from the last pattern acted upon.
    assign fire = seg_en && (state == ST_WAIT_STABLE) && (stable_cnt == CNT_MAX) &&
                  (last_none || (seg_q != last_pat));

    // Input register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            stable_cnt <= '0;
        end else begin
            seg_q <= seg_in;
            if (!seg_en || (seg_in != seg_q)) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

    // Lock FSM and last accepted pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT_STABLE;
            last_pat  <= '0;
            last_none <= 1'b1;
        end else if (!seg_en) begin
            state     <= ST_WAIT_STABLE;
            last_none <= 1'b1;
        end else begin
            case (state)
                ST_WAIT_STABLE: begin
                    if (stable_cnt == CNT_MAX) begin
                        if (fire) begin
                            last_pat  <= seg_q;
                            last_none <= 1'b0;
                        end
                        // If the bus moves on the very edge we lock, stay
                        // waiting; otherwise LOCKED would miss that change
                        // because seg_q catches up on the same edge.
                        state <= (seg_in != seg_q) ? ST_WAIT_STABLE : ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (seg_in != seg_q) begin
                        state <= ST_WAIT_STABLE;
                    end
                end
                default: state <= ST_WAIT_STABLE;
            endcase
        end
    end

    // Output side: handshake, blank flag, error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_out   <= '0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            overrun     <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                digit_valid <= 1'b0;
            end
            if (fire) begin
                if (dec_legal) begin
                    digit_out   <= dec_digit;
                    digit_valid <= 1'b1;
                    blank       <= 1'b0;
                    if (digit_valid && !digit_ready) begin
                        overrun <= 1'b1;
                    end
                end else if (seg_q == PAT_BLANK) begin
                    blank <= 1'b1;
                end else begin
                    err_pulse <= 1'b1;
                    blank     <= 1'b0;
                    if (err_count != {ERR_CNT_W{1'b1}}) begin
                        err_count <= err_count + err_one;
                    end
                end
            end
            // Clearing wins over a same-cycle increment or overrun.
            if (clr_err) begin
                err_count <= '0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_decoder
//
// Self-checking bench for seg_decoder. A behavioural reference model keeps a
// sliding window of the last STABLE_CYCLES bus samples and enables, and
// decides from that window and a pattern lookup table when a decode event is
// due and what it does to the outputs. Every output is compared after every
// clock edge, plus directed checks for the headline scenarios.
// -----------------------------------------------------------------------------
module tb_seg_decoder;

    localparam int SC = 3;
    localparam int EW = 8;
`ifdef SEG_DEC_HEX_EN
    localparam int DW   = 4;
    localparam int NDIG = 16;
`else
    localparam int DW   = 3;
    localparam int NDIG = 8;
`endif
    localparam int ERR_MAX = (1 << EW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = 7'b0;
    logic          seg_en = 1'b0;
    logic          digit_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] digit_out;
    logic          digit_valid;
    logic          blank;
    logic          err_pulse;
    logic [EW-1:0] err_count;
    logic          overrun;

    always #5 clk = ~clk;

    seg_decoder #(.STABLE_CYCLES(SC), .ERR_CNT_W(EW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .seg_en      (seg_en),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .blank       (blank),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .overrun     (overrun),
        .clr_err     (clr_err)
    );

    // ---------------- scoreboard counters ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] pat_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [6:0] samp_q [$];   // bus value taken at each of the last SC edges
    bit         en_q [$];     // seg_en at those edges (0 stands for reset)
    int         m_digit;
    bit         m_valid, m_blank, m_err_pulse, m_overrun;
    int         m_err_count;
    bit         m_last_none;
    logic [6:0] m_last;
    logic [6:0] illegal_q [$];

    // >=0 legal digit, -1 blank, -2 illegal
    function automatic int tb_decode(input logic [6:0] p);
        for (int i = 0; i < NDIG; i++) begin
            if (pat_tab[i] == p) return i;
        end
        if (p == 7'b1111111) return -1;
        return -2;
    endfunction

    task automatic model_reset();
        samp_q.delete();
        en_q.delete();
        for (int i = 0; i < SC; i++) begin
            samp_q.push_back(7'b0);
            en_q.push_back(1'b0);
        end
        m_digit = 0; m_valid = 0; m_blank = 0; m_err_pulse = 0;
        m_overrun = 0; m_err_count = 0; m_last_none = 1; m_last = '0;
    endtask

    // Compute the state after the coming edge from the inputs now applied.
    task automatic model_edge();
        bit         fire, pre_valid;
        logic [6:0] p;
        int         d;
        fire = 0;
        p = samp_q[SC-1];
        if (seg_en) begin
            fire = 1;
            for (int k = 0; k < SC; k++) if (samp_q[k] != p) fire = 0;
            for (int k = 1; k < SC; k++) if (!en_q[k]) fire = 0;
            if (!m_last_none && (p == m_last)) fire = 0;
        end
        pre_valid = m_valid;
        m_err_pulse = 0;
        if (m_valid && digit_ready) m_valid = 0;
        if (fire) begin
            d = tb_decode(p);
            if (d >= 0) begin
                if (pre_valid && !digit_ready) m_overrun = 1;
                m_digit = d; m_valid = 1; m_blank = 0;
            end else if (d == -1) begin
                m_blank = 1;
            end else begin
                m_err_pulse = 1; m_blank = 0;
                if (m_err_count < ERR_MAX) m_err_count++;
            end
            m_last = p;
            m_last_none = 0;
        end
        if (!seg_en) m_last_none = 1;
        if (clr_err) begin
            m_err_count = 0;
            m_overrun = 0;
        end
        samp_q.push_back(seg_in); void'(samp_q.pop_front());
        en_q.push_back(seg_en);   void'(en_q.pop_front());
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".digit_out"},   32'(digit_out),   32'(m_digit));
        chk({tag, ".digit_valid"}, 32'(digit_valid), 32'(m_valid));
        chk({tag, ".blank"},       32'(blank),       32'(m_blank));
        chk({tag, ".err_pulse"},   32'(err_pulse),   32'(m_err_pulse));
        chk({tag, ".err_count"},   32'(err_count),   32'(m_err_count));
        chk({tag, ".overrun"},     32'(overrun),     32'(m_overrun));
    endtask

    // ---------------- driver ----------------
    // Inputs are changed 1 time unit after a rising edge; outputs are
    // checked 1 time unit after the next rising edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input logic [6:0] p, input int n, input string tag);
        seg_in = p;
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int pulses;
        int idx;
        int r;
        logic [6:0] p;

        model_reset();
        for (int i = 0; i < 128; i++) begin
            p = 7'(i);
            if (tb_decode(p) == -2) illegal_q.push_back(p);
        end

        // Reset state
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;

        // First digit: latency and hold while not ready
        seg_en = 1'b1;
        digit_ready = 1'b0;
        seg_in = 7'b0100100;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step("first");
            lat++;
            if (digit_valid) break;
        end
        chk("first_latency", 32'(lat), 32'(SC + 1));
        hold(7'b0100100, 10, "first_hold");
        chk("first_digit", 32'(digit_out), 32'd2);
        chk("first_valid_held", 32'(digit_valid), 32'd1);

        // Accept, then keep the same pattern: no repeat
        digit_ready = 1'b1;
        step("accept2");
        digit_ready = 1'b0;
        hold(7'b0100100, 20, "no_repeat");
        chk("no_repeat_valid", 32'(digit_valid), 32'd0);

        // Glitchy bus, then a clean 1
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 7'b1111001 : 7'b0110000, 1, "toggle");
        hold(7'b1111001, SC + 3, "settle1");
        chk("glitch_digit", 32'(digit_out), 32'd1);
        chk("glitch_errs", 32'(err_count), 32'd0);
        chk("glitch_valid", 32'(digit_valid), 32'd1);
        digit_ready = 1'b1;
        step("accept1");
        digit_ready = 1'b0;

        // Single illegal pattern: exactly one pulse
        seg_in = 7'b1010101;
        pulses = 0;
        for (int i = 0; i < SC + 4; i++) begin
            step("illegal1");
            if (err_pulse) pulses++;
        end
        chk("single_err_pulse", 32'(pulses), 32'd1);
        chk("err_count_one", 32'(err_count), 32'd1);

        // Many illegal patterns: counter saturates
        for (int i = 0; i < ERR_MAX + 5; i++) begin
            idx = i % illegal_q.size();
            hold(illegal_q[idx], SC + 1, "illegal_many");
        end
        chk("err_saturated", 32'(err_count), 32'(ERR_MAX));
        clr_err = 1'b1;
        step("clr");
        clr_err = 1'b0;
        chk("err_cleared", 32'(err_count), 32'd0);

        // Overrun: 5 pending, then 7
        hold(7'b0010010, SC + 2, "pend5");
        chk("pend5_digit", 32'(digit_out), 32'd5);
        hold(7'b1111000, SC + 2, "over7");
        chk("over7_digit", 32'(digit_out), 32'd7);
        chk("over7_overrun", 32'(overrun), 32'd1);
        digit_ready = 1'b1;
        step("accept7");
        digit_ready = 1'b0;
        chk("accept7_valid", 32'(digit_valid), 32'd0);
        clr_err = 1'b1;
        step("clr2");
        clr_err = 1'b0;

        // Randomised traffic against the model
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      p = pat_tab[$urandom_range(0, NDIG - 1)];
            else if (r < 65) p = 7'b1111111;
            else if (r < 85) p = illegal_q[$urandom_range(0, illegal_q.size() - 1)];
            else             p = 7'($urandom_range(0, 127));
            seg_in = p;
            for (int j = 0; j < $urandom_range(1, SC + 2); j++) begin
                digit_ready = ($urandom_range(0, 3) == 0);
                clr_err = ($urandom_range(0, 30) == 0);
                seg_en = ($urandom_range(0, 19) != 0);
                step("random");
            end
        end
        digit_ready = 1'b0;
        clr_err = 1'b0;

        // Blank with a digit pending
        seg_en = 1'b0;
        seg_in = 7'b0110000;
        step("blank_prep");
        seg_en = 1'b1;
        hold(7'b0110000, SC + 3, "pend3");
        hold(7'b1111111, SC + 2, "blank");
        chk("blank_flag", 32'(blank), 32'd1);
        chk("blank_valid", 32'(digit_valid), 32'd1);
        chk("blank_digit", 32'(digit_out), 32'd3);

        // Drop enable mid-settle, then asynchronous reset
        seg_in = 7'b0011001;
        step("settle4");
        seg_en = 1'b0;
        step("en_low");
        step("en_low2");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
